// File: rtl/gray_counter.sv
// Up/down binary counter with a registered reflected-binary Gray view.
// bin and gray are both registered from the same next-state value, so they
// always change on the same edge and gray has no combinational input path.
module gray_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             step,
  output logic             wrap
);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;

  // Next-state: load beats counting; counting wraps modulo 2^WIDTH.
  always_comb begin
    bin_d  = bin_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      step_d = 1'b1;
      if (up_dn) begin
        bin_d  = bin_q + WIDTH'(1);
        wrap_d = &bin_q;
      end else begin
        bin_d  = bin_q - WIDTH'(1);
        wrap_d = ~|bin_q;
      end
    end
    // Gray is encoded from the next binary value, not the current one.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign step = step_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter (WIDTH = 4). The driver pushes the
// hand-computed expected outputs for each edge; monitors pop and compare
// after each rising edge and after each asynchronous reset assertion.
module tb_gray_counter;

  localparam int unsigned W = 4;

  typedef struct {
    int       id;
    logic [W-1:0] b;
    logic [W-1:0] g;
    logic     s;
    logic     w;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en = 1'b0;
  logic         up_dn = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_bin = '0;
  logic [W-1:0] bin;
  logic [W-1:0] gray;
  logic         step;
  logic         wrap;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass = 0;
  int   vec_id = 0;

  gray_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_bin (load_bin),
    .bin      (bin),
    .gray     (gray),
    .step     (step),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic check_pop();
    exp_t e;
    e = exp_q.pop_front();
    n_total++;
    if (bin === e.b && gray === e.g && step === e.s && wrap === e.w) begin
      n_pass++;
    end else begin
      $display("FAIL vec%0d: got bin=%b gray=%b step=%b wrap=%b, want bin=%b gray=%b step=%b wrap=%b",
               e.id, bin, gray, step, wrap, e.b, e.g, e.s, e.w);
    end
  endtask

  // Monitor: compare after every rising edge that has an expectation queued.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) check_pop();
  end

  // Monitor: reset must clear outputs without any clock edge.
  always @(negedge rst_n) begin
    #1;
    if (exp_q.size() > 0) check_pop();
  end

  task automatic push(input logic [W-1:0] b, input logic [W-1:0] g, input logic s,
                      input logic w);
    exp_t e;
    e.id = vec_id;
    e.b  = b;
    e.g  = g;
    e.s  = s;
    e.w  = w;
    vec_id++;
    exp_q.push_back(e);
  endtask

  // Drive one cycle's inputs at the falling edge and queue the expected result.
  task automatic cyc(input logic i_en, input logic i_up, input logic i_ld,
                     input logic [W-1:0] i_lb, input logic [W-1:0] b,
                     input logic [W-1:0] g, input logic s, input logic w);
    @(negedge clk);
    en       = i_en;
    up_dn    = i_up;
    load     = i_ld;
    load_bin = i_lb;
    push(b, g, s, w);
  endtask

  logic [W-1:0] gray_tbl [16];

  initial begin
    gray_tbl = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

    // Reset, checked before any clock edge is involved.
    #2;
    push(4'h0, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);

    // Full up sweep; wrap only on 1111 -> 0000.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 4'h0, W'((i + 1) % 16), gray_tbl[(i + 1) % 16], 1'b1,
          (i == 15));
    end

    // Down wrap from zero.
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 4'b1111, 4'b1000, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 4'b1110, 4'b1001, 1'b1, 1'b0);

    // Load beats en on the same edge, then counting resumes from the load.
    cyc(1'b1, 1'b1, 1'b1, 4'b1010, 4'b1010, 4'b1111, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 4'b1011, 4'b1110, 1'b1, 1'b0);

    // Count up to 0101, hold three cycles, then step down.
    cyc(1'b0, 1'b1, 1'b1, 4'b0011, 4'b0011, 4'b0010, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 4'b0100, 4'b0110, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 4'b0101, 4'b0111, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 4'h0, 4'b0101, 4'b0111, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 4'b0100, 4'b0110, 1'b1, 1'b0);

    // Load with en low: no step pulse.
    cyc(1'b0, 1'b1, 1'b1, 4'b1001, 4'b1001, 4'b1101, 1'b0, 1'b0);

    // Async reset between edges while bin = 1001, with en active.
    @(negedge clk);
    en    = 1'b1;
    up_dn = 1'b1;
    load  = 1'b0;
    #2;
    push(4'h0, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push(4'b0001, 4'b0001, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 4'b0010, 4'b0011, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 4'b0010, 4'b0011, 1'b0, 1'b0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gray_counter.md
# gray_counter

Parameterised up/down counter that keeps a binary count internally and presents it as registered reflected-binary Gray code, with a binary view alongside. It generates the Gray sequences that the Gray-to-binary decoder consumes. Typical uses are Gray-coded pointers and position codes, and driving decoder benches with legal Gray sequences.

## Interface
Parameters:
- WIDTH, 4, counter and code width in bits (WIDTH >= 2)

Ports:
- clk  input  1  rising-edge clock, the block's only clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  count enable; one step per clock while high
- up_dn  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous load strobe
- load_bin  input  WIDTH  binary value captured when load = 1
- bin  output  WIDTH  registered binary count
- gray  output  WIDTH  registered Gray code of bin: bin ^ (bin >> 1)
- step  output  1  registered pulse; high for the one cycle after a count step
- wrap  output  1  registered pulse; high for the one cycle after a count step that crossed the end of the range

## Operation
- Reset (rst_n low, async): bin = 0, gray = 0, step = 0, wrap = 0. Outputs hold these values until the first rising clk edge with rst_n high.
- Priority at each rising edge, evaluated in this order:
  1. load = 1: bin <= load_bin, gray <= load_bin ^ (load_bin >> 1). step and wrap go to 0. en and up_dn are ignored.
  2. Otherwise, en = 1 and up_dn = 1: bin <= bin + 1 modulo 2^WIDTH. step <= 1. wrap <= 1 only if the old bin was all-ones.
  3. Otherwise, en = 1 and up_dn = 0: bin <= bin - 1 modulo 2^WIDTH. step <= 1. wrap <= 1 only if the old bin was zero.
  4. Otherwise: bin and gray hold. step and wrap go to 0.
- gray is registered. It is computed from the next binary value, so gray and bin always change on the same edge. There is no combinational path from any input to gray.
- Arithmetic wraps naturally at WIDTH bits; no saturation.
- Invariant: gray == bin ^ (bin >> 1) in every cycle, including directly after reset and after a load.
- Invariant: consecutive count steps change exactly one bit of gray. This includes both wrap boundaries: all-ones to zero, and zero to all-ones.
- A load may change any number of gray bits. It is not counted as a step.
- Reversing up_dn between steps is legal. The next step simply goes the other way; there is no turnaround delay.

## Timing
- Latency: the input sampled at edge N is reflected on bin, gray, step and wrap immediately after edge N, with no further delay.
- Throughput: one step per clock while en is held high.
- step and wrap are single-cycle pulses. While en stays high, step stays high continuously. wrap pulses only on the crossing cycle.
- If rst_n is asserted mid-count, all outputs go to the reset values immediately, without waiting for clk. Any load or en active in that cycle is discarded. Counting resumes from 0 at the first edge after rst_n is released.
- load, en, up_dn and load_bin are sampled only at rising edges and must meet setup and hold around them.

## Test plan
- Reset then idle: hold rst_n low, then release with en = 0 and load = 0 for 5 clocks -> bin = 0000, gray = 0000, step = 0 and wrap = 0 throughout.
- Full up sweep (WIDTH = 4): en = 1, up_dn = 1 for 16 clocks -> gray follows 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000. Every step has Hamming distance 1. wrap = 1 only on the step 1000 -> 0000, where bin goes 1111 -> 0000. step = 1 on every cycle of the sweep.
- Down wrap: from reset, one clock with en = 1, up_dn = 0 -> bin = 1111, gray = 1000, wrap = 1, step = 1. A further step gives bin = 1110, gray = 1001, wrap = 0.
- Load priority: load = 1, load_bin = 1010, en = 1 on the same edge -> bin = 1010, gray = 1111, step = 0, wrap = 0. The next edge with en = 1, up_dn = 1 -> bin = 1011, gray = 1110.
- Hold and direction change: after counting up to bin = 0101 (gray 0111), drop en for 3 clocks -> no change, step = 0. Then en = 1, up_dn = 0 -> bin = 0100, gray = 0110.
- Async reset mid-count: assert rst_n low between edges while bin = 1001 -> bin = 0000 and gray = 0000 immediately, without a clk edge. After release, the first up step gives gray = 0001.
